// File: rtl/uart_rx.sv
// uart_rx: receive half of the DHT11 UART link.
// 8N1 asynchronous serial in, parallel byte out, mid-bit sampling, framing
// error and overrun detection, byte held until the consumer acknowledges it.
// Optional feature macro: UART_RX_PARITY_EN (frame becomes 8E1, adds the
// PARITY state and drives parity_err; without it parity_err is tied low).
module uart_rx #(
    parameter int CLK_FREQ  = 1_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_busy_q, rx_busy_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        parity_ok_s;

`ifdef UART_RX_PARITY_EN
    logic        parity_err_q, parity_err_d;
    logic        parity_bad_q, parity_bad_d;
    assign parity_ok_s = ~parity_bad_q;
    assign parity_err  = parity_err_q;
`else
    assign parity_ok_s = 1'b1;
    assign parity_err  = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Synchroniser, edge-detect history and all state/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            clk_count_q  <= 16'd0;
            bit_index_q  <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            state_q      <= state_d;
            clk_count_q  <= clk_count_d;
            bit_index_q  <= bit_index_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_busy_q    <= rx_busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // Next-state, bit sampling, byte hand-off and error pulse generation.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_busy_d   = rx_busy_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
        parity_bad_d = parity_bad_q;
`endif
        // An ack only matters while a byte is pending; a completing byte below overrides it.
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                clk_count_d = 16'd0;
                // Only a true 1->0 transition starts a frame, so a held-low line cannot retrigger.
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = S_START;
                    rx_busy_d = 1'b1;
                end else begin
                    rx_busy_d = 1'b0;
                end
            end
            S_START: begin
                if (clk_count_q == HALF_LAST) begin
                    clk_count_d = 16'd0;
                    if (!rx_s_q) begin
                        state_d     = S_DATA;
                        bit_index_d = 3'd0;
                    end else begin
                        state_d   = S_IDLE;
                        rx_busy_d = 1'b0;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            S_DATA: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d          = 16'd0;
                    shift_d[bit_index_q] = rx_s_q;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d     = S_PARITY;
`else
                        state_d     = S_STOP;
`endif
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d = 16'd0;
                    state_d     = S_STOP;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if ((^shift_q) != rx_s_q) begin
                        parity_err_d = 1'b1;
                        parity_bad_d = 1'b1;
                    end else begin
                        parity_bad_d = 1'b0;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (clk_count_q == BIT_LAST) begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    clk_count_d = 16'd0;
                    state_d     = S_IDLE;
                    rx_busy_d   = 1'b0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (parity_ok_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q && !rx_ack;
                    end else begin
                        rx_data_d = rx_data_q;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                clk_count_d = 16'd0;
                rx_busy_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: scoreboard of expected bytes, frames driven at 104 clk/bit.
module tb_uart_rx;

    localparam int BIT = 104;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 991 + BIT;
`else
    localparam int LAT = 991;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int frame_cnt = 0, overrun_cnt = 0, parity_cnt = 0, wide_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic       fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] sb[$];

    uart_rx dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one frame; caller must be sitting just after a negedge.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (BIT) @(negedge clk);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on each stored byte, counts error pulses.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rx_valid && (!valid_prev || rx_data != data_prev)) begin
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
                end
            end
            if (frame_err) frame_cnt++;
            if (overrun) overrun_cnt++;
            if (parity_err) parity_cnt++;
            if ((frame_err && fe_prev) || (overrun && ov_prev) || (parity_err && pe_prev)) wide_cnt++;
            if (rx_busy) busy_seen = 1'b1;
        end
        valid_prev = rx_valid;
        data_prev  = rx_data;
        fe_prev    = frame_err;
        ov_prev    = overrun;
        pe_prev    = parity_err;
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'h0);
        check("rst_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_busy", {31'd0, rx_busy}, 32'h0);
        check("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'h0);
        repeat (5) @(negedge clk);

        // 1: good byte, latency
        start_cyc = cyc;
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        lat = rise_cyc - start_cyc;
        check("latency_ok", {31'd0, (lat >= LAT - 2) && (lat <= LAT + 2)}, 32'h1);
        check("t1_valid", {31'd0, rx_valid}, 32'h1);
        check("t1_no_err", frame_cnt + overrun_cnt + parity_cnt, 32'h0);
        ack_pulse();
        check("t1_ack_clears", {31'd0, rx_valid}, 32'h0);
        ack_pulse();
        check("t1_ack_idle", {31'd0, rx_valid}, 32'h0);
        repeat (20) @(negedge clk);

        // 2: start glitch
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t2_busy_seen", {31'd0, busy_seen}, 32'h1);
        check("t2_busy_low", {31'd0, rx_busy}, 32'h0);
        check("t2_no_valid", {31'd0, rx_valid}, 32'h0);
        check("t2_no_err", frame_cnt + overrun_cnt + parity_cnt, 32'h0);
        repeat (20) @(negedge clk);

        // 3: framing error
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_frame_err", frame_cnt, 32'd1);
        check("t3_data_kept", {24'd0, rx_data}, 32'hA5);
        check("t3_no_valid", {31'd0, rx_valid}, 32'h0);

        // 4: overrun, then ack on completion cycle
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("t4_overrun", overrun_cnt, 32'd1);
        check("t4_data", {24'd0, rx_data}, 32'h22);
        check("t4_valid", {31'd0, rx_valid}, 32'h1);
        ack_pulse();
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        send_byte(8'h33, 1'b1, 1'b0);
        fork
            send_byte(8'h44, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                @(negedge clk);
                check("t4_ack_valid", {31'd0, rx_valid}, 32'h1);
            end
        join
        repeat (5) @(negedge clk);
        check("t4_no_overrun", overrun_cnt, 32'd1);
        check("t4_data2", {24'd0, rx_data}, 32'h44);
        ack_pulse();

        // 5: reset mid-frame
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                repeat (BIT * 5 + 52) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("t5_rst_busy", {31'd0, rx_busy}, 32'h0);
                check("t5_rst_data", {24'd0, rx_data}, 32'h0);
            end
        join
        repeat (20) @(negedge clk);
        sb.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_data", {24'd0, rx_data}, 32'h0F);
        check("t5_no_err", frame_cnt + overrun_cnt, 32'd2);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // 6: parity
        send_byte(8'h07, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_parity_err", parity_cnt, 32'd1);
        check("t6_no_valid", {31'd0, rx_valid}, 32'h0);
        sb.push_back(8'h07);
        send_byte(8'h07, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("t6_data", {24'd0, rx_data}, 32'h07);
        check("t6_parity_cnt", parity_cnt, 32'd1);
`else
        check("parity_tied", parity_cnt, 32'd0);
`endif

        check("pulse_width", wide_cnt, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
